// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory loader: FSM state encoding
// and the default frame start byte.
package mips_pkg;
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/imem_word_packer.sv
// Assembles payload bytes MSB-first into a 32-bit word and keeps the running
// XOR checksum over every payload byte.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic [7:0]  csum
);
  logic [31:0] word;

  // The loader captures word_nxt on the 4th byte so the write goes out one cycle later.
  assign word_nxt = {word[23:0], byte_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      csum <= '0;
    end else if (clear) begin
      word <= '0;
      csum <= '0;
    end else if (shift) begin
      word <= word_nxt;
      csum <= csum ^ byte_in;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader: parses SYNC/count/payload/checksum frames, writes words
// into instruction memory and holds the core in reset until a load verifies.
module imem_loader
  import mips_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] im_add,
  output logic [31:0]       im_data,
  output logic              im_write,
  output logic              core_hold,
  output logic              done,
  output logic              err
);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state;
  logic [15:0]       n_words;
  logic [16:0]       wcnt;
  logic [1:0]        bcnt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word_nxt;
  logic [7:0]        csum;
  logic              accept, start, shift;
  logic [15:0]       n_next;
  logic [16:0]       wcnt_inc;

  assign accept   = in_valid && in_ready;
  assign start    = accept && (in_data == SYNC) &&
                    (state == IDLE || state == DONE || state == ERR);
  assign shift    = accept && (state == DATA);
  assign n_next   = {n_words[15:8], in_data};
  assign wcnt_inc = wcnt + 17'd1;

  imem_word_packer u_pack (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .shift    (shift),
    .byte_in  (in_data),
    .word_nxt (word_nxt),
    .csum     (csum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      im_write  <= 1'b0;
      im_add    <= '0;
      im_data   <= '0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      n_words   <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      addr      <= '0;
    end else begin
      // in_ready is only ever dropped for the single WRITE cycle.
      im_write <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state     <= LEN_HI;
          addr      <= '0;
          bcnt      <= '0;
          wcnt      <= '0;
          core_hold <= 1'b1;
          done      <= 1'b0;
          err       <= 1'b0;
        end
        LEN_HI: if (accept) begin
          n_words[15:8] <= in_data;
          state         <= LEN_LO;
        end
        LEN_LO: if (accept) begin
          n_words[7:0] <= in_data;
          if ({1'b0, n_next} > MAX_WORDS) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (n_next == 16'd0) begin
            state <= CHECK;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            state    <= WRITE;
            in_ready <= 1'b0;
            im_write <= 1'b1;
            im_data  <= word_nxt;
            im_add   <= addr;
          end
        end
        WRITE: begin
          addr  <= addr + ADDR_W'(1);
          wcnt  <= wcnt_inc;
          state <= (wcnt_inc == {1'b0, n_words}) ? CHECK : DATA;
        end
        CHECK: if (accept) begin
          if (in_data == csum) begin
            state     <= DONE;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed frames into imem_loader; expected writes go into a scoreboard queue
// that a monitor drains whenever im_write is seen.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  im_add;
  logic [31:0] im_data;
  logic        im_write;
  logic        core_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;
  logic [39:0] wq[$];

  imem_loader #(.ADDR_W(8), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_add(im_add), .im_data(im_data),
    .im_write(im_write), .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && !in_ready) low_cnt++;
    if (!rst && im_write) begin
      chk("ready_low_in_write", {63'd0, in_ready}, 64'd0);
      if (wq.size() == 0) chk("unexpected_write", {24'd0, im_add, im_data}, 64'd0);
      else chk("write_addr_data", {24'd0, im_add, im_data}, {24'd0, wq.pop_front()});
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send(input logic [7:0] b);
    logic rdy;
    int guard;
    rdy = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!rdy) begin
      rdy = in_ready;
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        chk("send_timeout", 64'd0, 64'd1);
        rdy = 1'b1;
      end
    end
  endtask

  task automatic send_all(input logic [7:0] f[$]);
    foreach (f[i]) send(f[i]);
    in_valid = 1'b0;
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [31:0] d);
    wq.push_back({a, d});
  endtask

  task automatic status(input string name, input logic d, input logic e, input logic h);
    @(negedge clk);
    chk(name, {61'd0, done, err, core_hold}, {61'd0, d, e, h});
    chk({name, "_pending"}, 64'(wq.size()), 64'd0);
  endtask

  task automatic chk_reset(input string name);
    chk(name, {im_add, im_data, in_ready, core_hold, im_write, done, err},
        {8'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    logic [7:0] f[$];
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    chk_reset("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Two words; checksum byte is the XOR of the eight payload bytes = A4.
    exp_wr(8'd0, 32'h20080005); exp_wr(8'd1, 32'h8C010004);
    f = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04, 8'hA4};
    send_all(f);
    status("good_frame", 1'b1, 1'b0, 1'b0);

    // Same frame, wrong checksum: writes still happen, then error.
    exp_wr(8'd0, 32'h20080005); exp_wr(8'd1, 32'h8C010004);
    f = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00};
    send_all(f);
    status("bad_csum", 1'b0, 1'b1, 1'b1);

    // N = 257 exceeds the 256-word memory.
    f = '{8'hA5, 8'h01, 8'h01};
    send_all(f);
    status("too_long", 1'b0, 1'b1, 1'b1);

    // Empty frame: checksum of nothing is 00.
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_all(f);
    status("empty_frame", 1'b1, 1'b0, 1'b0);

    // Back-to-back bytes, a leading junk byte, and SYNC values as payload.
    // csum = A5^A5^A5^A5 ^ 00^00^00^01 ^ 12^34^56^78 = 01 ^ 08 = 09.
    exp_wr(8'd0, 32'hA5A5A5A5); exp_wr(8'd1, 32'h00000001); exp_wr(8'd2, 32'h12345678);
    low_cnt = 0;
    f = '{8'h33, 8'hA5, 8'h00, 8'h03, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
          8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_all(f);
    status("streaming", 1'b1, 1'b0, 1'b0);
    chk("ready_low_cycles", 64'(low_cnt), 64'd3);

    // Reset after the 2nd payload byte, then a clean one-word frame.
    f = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    send_all(f);
    rst = 1'b1;
    #1;
    chk_reset("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // csum = DE^AD^BE^EF = 22.
    exp_wr(8'd0, 32'hDEADBEEF);
    f = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_all(f);
    status("after_reset", 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
